// File: rtl/mem_stage_wait.sv
// Memory stage with a fixed multi-cycle data memory.
// A load/store stalls upstream (freeze) for WAIT_CYCLES+1 cycles. The access
// completes in DONE, and the MEM/WB register then captures the result.
// Optional feature macro: MEM_RANGE_ERR_EN adds a sticky registered
// range_err output that flags completed out-of-range accesses.
module mem_stage_wait #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  Dest_in,
    output logic        freeze,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  Dest_out
`ifdef MEM_RANGE_ERR_EN
    ,
    output logic        range_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Debug view of the controller: checkers can bind to dbg.state / dbg.cnt.
    typedef struct packed {
        state_t          state;
        logic [CW-1:0]   cnt;
    } dbg_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wb_en_q, wb_en_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic [31:0]   alu_result_q, alu_result_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic [3:0]    dest_q, dest_d;
`ifdef MEM_RANGE_ERR_EN
    logic          range_err_q, range_err_d;
`endif
    dbg_t          dbg;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          is_store;
    logic          is_load;
    logic [31:0]   offset;
    logic [31:0]   idx_full;
    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   rd_data;
    logic          mem_we;

    // Address decode; a simultaneous read+write request is a store.
    always_comb begin
        req      = MEM_R_EN_in | MEM_W_EN_in;
        is_store = MEM_W_EN_in;
        is_load  = MEM_R_EN_in & ~MEM_W_EN_in;
        offset   = ALU_result_in - 32'(BASE_ADDR);
        idx_full = offset >> 2;
        in_range = (ALU_result_in >= 32'(BASE_ADDR)) && (idx_full < 32'(DEPTH));
        idx      = idx_full[AW-1:0];
        rd_data  = in_range ? mem[idx] : 32'h0;
    end

    // Controller next state, freeze, and MEM/WB register next values.
    // Outputs default to a bubble; only a non-memory IDLE cycle or DONE
    // lets the inputs through.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        freeze       = 1'b0;
        mem_we       = 1'b0;
        wb_en_d      = 1'b0;
        mem_r_en_d   = 1'b0;
        alu_result_d = 32'h0;
        mem_data_d   = 32'h0;
        dest_d       = 4'h0;
`ifdef MEM_RANGE_ERR_EN
        range_err_d  = range_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    freeze  = 1'b1;
                    state_d = ACCESS;
                    cnt_d   = '0;
                end else begin
                    wb_en_d      = WB_EN_in;
                    mem_r_en_d   = 1'b0;
                    alu_result_d = ALU_result_in;
                    dest_d       = Dest_in;
                end
            end
            ACCESS: begin
                freeze = 1'b1;
                if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                mem_we       = is_store & in_range & ~rst;
                wb_en_d      = WB_EN_in;
                mem_r_en_d   = is_load;
                alu_result_d = ALU_result_in;
                dest_d       = Dest_in;
                mem_data_d   = is_load ? rd_data : 32'h0;
`ifdef MEM_RANGE_ERR_EN
                range_err_d  = range_err_q | ~in_range;
`endif
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state and MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wb_en_q      <= 1'b0;
            mem_r_en_q   <= 1'b0;
            alu_result_q <= 32'h0;
            mem_data_q   <= 32'h0;
            dest_q       <= 4'h0;
`ifdef MEM_RANGE_ERR_EN
            range_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_en_q      <= wb_en_d;
            mem_r_en_q   <= mem_r_en_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            dest_q       <= dest_d;
`ifdef MEM_RANGE_ERR_EN
            range_err_q  <= range_err_d;
`endif
        end
    end

    // Data array write; the read in DONE sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= val_Rm_in;
        end
    end

    assign dbg.state      = state_q;
    assign dbg.cnt        = cnt_q;

    assign WB_EN_out      = wb_en_q;
    assign MEM_R_EN_out   = mem_r_en_q;
    assign ALU_result_out = alu_result_q;
    assign mem_data_out   = mem_data_q;
    assign Dest_out       = dest_q;
`ifdef MEM_RANGE_ERR_EN
    assign range_err      = range_err_q;
`endif

endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench for mem_stage_wait with default parameters
// (DEPTH=64, BASE_ADDR=1024, WAIT_CYCLES=4).
module tb_mem_stage_wait;

    logic        clk;
    logic        rst;
    logic        WB_EN_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic [31:0] ALU_result_in;
    logic [31:0] val_Rm_in;
    logic [3:0]  Dest_in;
    logic        freeze;
    logic        WB_EN_out;
    logic        MEM_R_EN_out;
    logic [31:0] ALU_result_out;
    logic [31:0] mem_data_out;
    logic [3:0]  Dest_out;
`ifdef MEM_RANGE_ERR_EN
    logic        range_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_wait dut (
        .clk            (clk),
        .rst            (rst),
        .WB_EN_in       (WB_EN_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .ALU_result_in  (ALU_result_in),
        .val_Rm_in      (val_Rm_in),
        .Dest_in        (Dest_in),
        .freeze         (freeze),
        .WB_EN_out      (WB_EN_out),
        .MEM_R_EN_out   (MEM_R_EN_out),
        .ALU_result_out (ALU_result_out),
        .mem_data_out   (mem_data_out),
        .Dest_out       (Dest_out)
`ifdef MEM_RANGE_ERR_EN
        ,
        .range_err      (range_err)
`endif
    );

    // Clock and overall time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        WB_EN_in      = 1'b0;
        MEM_R_EN_in   = 1'b0;
        MEM_W_EN_in   = 1'b0;
        ALU_result_in = 32'h0;
        val_Rm_in     = 32'h0;
        Dest_in       = 4'h0;
    endtask

    // Drives one memory op, holds it while frozen, and returns right after
    // the edge that loads the result. Checks freeze length and the bubble.
    task automatic mem_op(input logic r, input logic w, input logic wb,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] dest);
        int fcyc;
        WB_EN_in      = wb;
        MEM_R_EN_in   = r;
        MEM_W_EN_in   = w;
        ALU_result_in = addr;
        val_Rm_in     = data;
        Dest_in       = dest;
        #1;
        fcyc = 0;
        while (freeze === 1'b1 && fcyc < 20) begin
            fcyc++;
            step();
        end
        n_checks++;
        if (fcyc !== 5) begin
            n_fail++;
            $display("FAIL freeze_len addr=%0d: got %0d cycles, expected 5", addr, fcyc);
        end
        n_checks++;
        if (WB_EN_out !== 1'b0 || ALU_result_out !== 32'h0 || Dest_out !== 4'h0) begin
            n_fail++;
            $display("FAIL bubble addr=%0d: got wb=%b alu=%h dest=%h, expected 0/0/0",
                     addr, WB_EN_out, ALU_result_out, Dest_out);
        end
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) step();
        n_checks++;
        if (freeze !== 1'b0 || WB_EN_out !== 1'b0 || MEM_R_EN_out !== 1'b0 ||
            ALU_result_out !== 32'h0 || mem_data_out !== 32'h0 || Dest_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fz=%b wb=%b r=%b alu=%h md=%h dest=%h, expected all 0",
                     freeze, WB_EN_out, MEM_R_EN_out, ALU_result_out, mem_data_out, Dest_out);
        end
`ifdef MEM_RANGE_ERR_EN
        n_checks++;
        if (range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_range_err: got %b, expected 0", range_err);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_nonmem();
        WB_EN_in      = 1'b1;
        ALU_result_in = 32'h25;
        Dest_in       = 4'd3;
        #1;
        n_checks++;
        if (freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmem_freeze: got %b, expected 0", freeze);
        end
        step();
        n_checks++;
        if (WB_EN_out !== 1'b1 || ALU_result_out !== 32'h25 || Dest_out !== 4'd3 ||
            MEM_R_EN_out !== 1'b0 || mem_data_out !== 32'h0 || freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL nonmem_result: got wb=%b alu=%h dest=%0d r=%b md=%h fz=%b, expected 1/25/3/0/0/0",
                     WB_EN_out, ALU_result_out, Dest_out, MEM_R_EN_out, mem_data_out, freeze);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_store_load();
        mem_op(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0);
        n_checks++;
        if (WB_EN_out !== 1'b0 || MEM_R_EN_out !== 1'b0 || mem_data_out !== 32'h0 ||
            ALU_result_out !== 32'd1028) begin
            n_fail++;
            $display("FAIL store_result: got wb=%b r=%b md=%h alu=%0d, expected 0/0/0/1028",
                     WB_EN_out, MEM_R_EN_out, mem_data_out, ALU_result_out);
        end
        mem_op(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd5);
        n_checks++;
        if (mem_data_out !== 32'hDEADBEEF || MEM_R_EN_out !== 1'b1 || WB_EN_out !== 1'b1 ||
            Dest_out !== 4'd5 || ALU_result_out !== 32'd1028) begin
            n_fail++;
            $display("FAIL load_result: got md=%h r=%b wb=%b dest=%0d alu=%0d, expected deadbeef/1/1/5/1028",
                     mem_data_out, MEM_R_EN_out, WB_EN_out, Dest_out, ALU_result_out);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_out_of_range();
        mem_op(1'b0, 1'b1, 1'b0, 32'd1024, 32'hA5A50000, 4'd0);
        mem_op(1'b0, 1'b1, 1'b0, 32'd1276, 32'h63636363, 4'd0);
`ifdef MEM_RANGE_ERR_EN
        n_checks++;
        if (range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_err_inrange: got %b, expected 0", range_err);
        end
`endif
        mem_op(1'b0, 1'b1, 1'b0, 32'd1020, 32'h11111111, 4'd0);
`ifdef MEM_RANGE_ERR_EN
        n_checks++;
        if (range_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_err_low: got %b, expected 1", range_err);
        end
`endif
        mem_op(1'b0, 1'b1, 1'b0, 32'd1280, 32'h22222222, 4'd0);
        mem_op(1'b1, 1'b0, 1'b1, 32'd1020, 32'h0, 4'd1);
        n_checks++;
        if (mem_data_out !== 32'h0 || MEM_R_EN_out !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_load_low: got md=%h r=%b, expected 0/1", mem_data_out, MEM_R_EN_out);
        end
        mem_op(1'b1, 1'b0, 1'b1, 32'd1280, 32'h0, 4'd2);
        n_checks++;
        if (mem_data_out !== 32'h0 || MEM_R_EN_out !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_load_high: got md=%h r=%b, expected 0/1", mem_data_out, MEM_R_EN_out);
        end
        mem_op(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 4'd3);
        n_checks++;
        if (mem_data_out !== 32'hA5A50000) begin
            n_fail++;
            $display("FAIL word0_kept: got %h, expected a5a50000", mem_data_out);
        end
        mem_op(1'b1, 1'b0, 1'b1, 32'd1276, 32'h0, 4'd4);
        n_checks++;
        if (mem_data_out !== 32'h63636363) begin
            n_fail++;
            $display("FAIL word63_kept: got %h, expected 63636363", mem_data_out);
        end
`ifdef MEM_RANGE_ERR_EN
        n_checks++;
        if (range_err !== 1'b1) begin
            n_fail++;
            $display("FAIL range_err_sticky: got %b, expected 1", range_err);
        end
`endif
        clear_inputs();
        step();
    endtask

    task automatic test_both_en();
        mem_op(1'b1, 1'b1, 1'b1, 32'd1036, 32'h00000077, 4'd2);
        n_checks++;
        if (mem_data_out !== 32'h0 || MEM_R_EN_out !== 1'b0 || WB_EN_out !== 1'b1) begin
            n_fail++;
            $display("FAIL both_en_result: got md=%h r=%b wb=%b, expected 0/0/1",
                     mem_data_out, MEM_R_EN_out, WB_EN_out);
        end
        mem_op(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0, 4'd2);
        n_checks++;
        if (mem_data_out !== 32'h00000077) begin
            n_fail++;
            $display("FAIL both_en_stored: got %h, expected 00000077", mem_data_out);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        mem_op(1'b0, 1'b1, 1'b0, 32'd1032, 32'h11112222, 4'd0);
        MEM_W_EN_in   = 1'b1;
        ALU_result_in = 32'd1032;
        val_Rm_in     = 32'hBAD0BAD0;
        step();
        step();
        rst = 1'b1;
        clear_inputs();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (freeze !== 1'b0 || WB_EN_out !== 1'b0 || ALU_result_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got fz=%b wb=%b alu=%h, expected 0/0/0",
                     freeze, WB_EN_out, ALU_result_out);
        end
        step();
        mem_op(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, 4'd6);
        n_checks++;
        if (mem_data_out !== 32'h11112222) begin
            n_fail++;
            $display("FAIL reset_mid_store_dropped: got %h, expected 11112222", mem_data_out);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        mem_op(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 4'd7);
        n_checks++;
        if (mem_data_out !== 32'hA5A50000 || Dest_out !== 4'd7) begin
            n_fail++;
            $display("FAIL b2b_first: got md=%h dest=%0d, expected a5a50000/7", mem_data_out, Dest_out);
        end
        mem_op(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 4'd8);
        n_checks++;
        if (mem_data_out !== 32'hDEADBEEF || Dest_out !== 4'd8) begin
            n_fail++;
            $display("FAIL b2b_second: got md=%h dest=%0d, expected deadbeef/8", mem_data_out, Dest_out);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_nonmem();
        test_store_load();
        test_out_of_range();
        test_both_en();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
